// File: rtl/whack_judge.sv
// whack_judge: turns raw hole buttons plus the visible-mole mask into clean, serialized
// one-cycle hit pulses for the score counter.
//
// Pipeline per button: 2-flop synchronizer -> debouncer -> rising-edge press detect ->
// judge (enable and mole_active checked) -> pending set -> lowest-index-first serializer.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   enable        high while the game is in START; hits judged only when high
//   btn           raw asynchronous buttons, active high
//   mole_active   synchronous mask of visible moles
//   score_trigger registered one-cycle pulse per accepted hit
//   hit_mask      registered one-hot index of the reported hit, zero when no pulse
//   miss_trigger  (only with WHACK_MISS_EN) one-cycle pulse after any enabled press on an
//                 empty hole
//
// Optional feature macro: WHACK_MISS_EN adds the miss_trigger output and its logic.
module whack_judge #(
  parameter int unsigned N_HOLES         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [N_HOLES-1:0] btn,
  input  logic [N_HOLES-1:0] mole_active,
  output logic               score_trigger,
  output logic [N_HOLES-1:0] hit_mask
`ifdef WHACK_MISS_EN
  ,
  output logic               miss_trigger
`endif
);

  // Counter only needs to hold 0 .. DEBOUNCE_CYCLES-1; reaching DEBOUNCE_CYCLES flips instead.
  localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [N_HOLES-1:0] sync1_q, sync2_q;
  logic [N_HOLES-1:0] db_q, db_d;
  logic [N_HOLES-1:0] db_prev_q;
  logic [CntW-1:0]    cnt_q [N_HOLES];
  logic [CntW-1:0]    cnt_d [N_HOLES];
  logic [N_HOLES-1:0] pending_q, pending_d;
  logic               score_trigger_q, score_trigger_d;
  logic [N_HOLES-1:0] hit_mask_q, hit_mask_d;

  logic [N_HOLES-1:0] press;
  logic [N_HOLES-1:0] new_hits;
  logic [N_HOLES-1:0] grant;

  // Debouncer: free-running, independent of enable.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < int'(N_HOLES); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level only; release never counts.
  assign press    = db_q & ~db_prev_q;
  assign new_hits = enable ? (press & mole_active) : '0;
  // Isolate the lowest set pending bit.
  assign grant    = pending_q & (~pending_q + N_HOLES'(1));

  always_comb begin
    pending_d       = '0;
    score_trigger_d = 1'b0;
    hit_mask_d      = '0;
    if (enable) begin
      pending_d       = (pending_q & ~grant) | new_hits;
      score_trigger_d = |pending_q;
      hit_mask_d      = grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q         <= '0;
      sync2_q         <= '0;
      db_q            <= '0;
      db_prev_q       <= '0;
      for (int i = 0; i < int'(N_HOLES); i++) cnt_q[i] <= '0;
      pending_q       <= '0;
      score_trigger_q <= 1'b0;
      hit_mask_q      <= '0;
    end else begin
      sync1_q         <= btn;
      sync2_q         <= sync1_q;
      db_q            <= db_d;
      db_prev_q       <= db_q;
      for (int i = 0; i < int'(N_HOLES); i++) cnt_q[i] <= cnt_d[i];
      pending_q       <= pending_d;
      score_trigger_q <= score_trigger_d;
      hit_mask_q      <= hit_mask_d;
    end
  end

  assign score_trigger = score_trigger_q;
  assign hit_mask      = hit_mask_q;

`ifdef WHACK_MISS_EN
  logic miss_trigger_q, miss_trigger_d;

  // Judged on the same edge as new_hits, so it leads the serializer by one cycle.
  assign miss_trigger_d = enable & (|(press & ~mole_active));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_trigger_q <= 1'b0;
    end else begin
      miss_trigger_q <= miss_trigger_d;
    end
  end

  assign miss_trigger = miss_trigger_q;
`endif

endmodule

// File: tb/tb_whack_judge.sv
module tb_whack_judge;
  localparam int N  = 4;
  localparam int DB = 4;
  // Cycles from the first edge sampling a raw press to the edge launching its first pulse.
  localparam int Lat = DB + 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] mole_active = '0;
  logic         score_trigger;
  logic [N-1:0] hit_mask;
`ifdef WHACK_MISS_EN
  logic         miss_trigger;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [N-1:0] mask;
    int           at;
  } exp_t;

  exp_t exp_q[$];
  int   miss_q[$];

  whack_judge #(
    .N_HOLES        (N),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .btn          (btn),
    .mole_active  (mole_active),
    .score_trigger(score_trigger),
    .hit_mask     (hit_mask)
`ifdef WHACK_MISS_EN
    ,
    .miss_trigger (miss_trigger)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every DUT pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (score_trigger) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {28'd0, hit_mask}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("hit_mask", {28'd0, hit_mask}, {28'd0, e.mask});
          check("pulse_cycle", cyc, e.at);
        end
      end else if (hit_mask != '0) begin
        check("idle_hit_mask", {28'd0, hit_mask}, 32'd0);
      end
    end
  end

`ifdef WHACK_MISS_EN
  always @(negedge clk) begin
    if (rst_n && miss_trigger) begin
      if (miss_q.size() == 0) begin
        check("unexpected_miss", 32'd1, 32'd0);
      end else begin
        int at;
        at = miss_q.pop_front();
        check("miss_cycle", cyc, at);
      end
    end
  end
`endif

  // One press transaction: optional sub-threshold glitch, then press set p held for hold cycles.
  task automatic run_txn(input logic [N-1:0] p, input logic [N-1:0] m, input logic e,
                         input bit glitch, input int hold);
    int t;
    int k;
    enable      = e;
    mole_active = m;
    if (glitch) begin
      btn = N'($urandom);
      wait_cycles($urandom_range(1, DB - 1));
      btn = '0;
      wait_cycles(DB + 4);
    end
    t   = cyc;
    btn = p;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      if (e && p[i] && m[i]) begin
        exp_q.push_back('{mask: N'(1) << i, at: t + Lat + k});
        k++;
      end
    end
`ifdef WHACK_MISS_EN
    if (e && ((p & ~m) != '0)) miss_q.push_back(t + Lat - 1);
`endif
    wait_cycles(hold);
    btn = '0;
    wait_cycles(24);
  endtask

  initial begin
    int t;
    int cnt;
    #1;
    check("reset_score_trigger", {31'd0, score_trigger}, 32'd0);
    check("reset_hit_mask", {28'd0, hit_mask}, 32'd0);
    #11 rst_n = 1'b1;
    wait_cycles(2);
    mon_en = 1'b1;

    // Single hit, held: exactly one pulse.
    run_txn(4'b0100, 4'b0100, 1'b1, 1'b0, 20);
    // Simultaneous presses: three back-to-back pulses, lowest index first.
    run_txn(4'b1011, 4'b1111, 1'b1, 1'b0, 8);
    // Gating: enable low, then empty hole.
    run_txn(4'b1000, 4'b1111, 1'b0, 1'b0, 8);
    run_txn(4'b1000, 4'b0111, 1'b1, 1'b0, 8);

    // Bounce on btn[1]: toggle every 2 cycles for 20 cycles, then hold.
    enable      = 1'b1;
    mole_active = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      btn = 4'b0010;
      wait_cycles(2);
      btn = 4'b0000;
      wait_cycles(2);
    end
    t   = cyc;
    btn = 4'b0010;
    exp_q.push_back('{mask: 4'b0010, at: t + Lat});
    wait_cycles(12);
    btn = '0;
    wait_cycles(24);

    // Asynchronous reset mid-queue drops the remaining hit.
    mole_active = 4'b1111;
    t   = cyc;
    btn = 4'b0110;
    mon_en = 1'b0;
    wait_cycles(Lat);
    #1;
    check("pre_reset_pulse", {31'd0, score_trigger}, 32'd1);
    rst_n = 1'b0;
    btn   = '0;
    #1;
    check("reset_async_trigger", {31'd0, score_trigger}, 32'd0);
    check("reset_async_mask", {28'd0, hit_mask}, 32'd0);
    wait_cycles(2);
    #3 rst_n = 1'b1;
    mon_en = 1'b1;
    wait_cycles(30);

    // Enable drop after the first of three queued pulses.
    mon_en = 1'b0;
    t   = cyc;
    btn = 4'b0111;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (score_trigger) cnt++;
      if (cyc == t + Lat) begin
        check("drop_first_pulse", {31'd0, score_trigger}, 32'd1);
        enable = 1'b0;
      end
      if (i == 15) btn = '0;
    end
    vectors++;
    if (cnt < 1 || cnt > 2) begin
      miscompares++;
      $display("FAIL enable_drop_pulses: got %0d expected 1..2", cnt);
    end
    wait_cycles(2);
    enable = 1'b1;
    mon_en = 1'b1;
    wait_cycles(20);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      run_txn(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              $urandom_range(DB + 1, 12));
    end

    wait_cycles(10);
    check("leftover_expected_pulses", exp_q.size(), 32'd0);
    check("leftover_expected_misses", miss_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
